// File: rtl/seg_display_pkg.sv
// Shared constants, segment patterns and arbiter state encoding for seg_display_arbiter.
package seg_display_pkg;

   localparam int VALUE_W = 16;
   localparam int SEG_W   = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns indexed by hex nibble value.
   localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHOW    = 2'd1,
      EXPIRED = 2'd2
   } state_e;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
   import seg_display_pkg::*;
(
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg
);

   // Table lookup of the digit pattern for one nibble.
   always_comb begin
      seg = HEX_SEG[nibble];
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-requester round-robin arbiter for a 4-digit seven-segment display with
// a minimum owner dwell time. Optional leading-zero blanking is enabled by
// defining SEG_BLANK_LEADING_ZEROS_EN.
module seg_display_arbiter
   import seg_display_pkg::*;
#(
   parameter int DWELL_CYCLES = 50_000_000,
   parameter int CNT_W        = 26
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   input  logic [VALUE_W-1:0] req_data0,
   input  logic [VALUE_W-1:0] req_data1,
   output logic [1:0]         req_ready,
   output logic [SEG_W-1:0]   dis_a,
   output logic [SEG_W-1:0]   dis_b,
   output logic [SEG_W-1:0]   dis_c,
   output logic [SEG_W-1:0]   dis_d,
   output logic               owner,
   output logic               owner_valid
);

   // Counter value one cycle before saturation, and the saturation value itself.
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DWELL_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

   state_e             state_q, state_d;
   logic               owner_q, owner_d;
   logic               owner_valid_q, owner_valid_d;
   logic               ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SEG_W-1:0]   dis_a_q, dis_a_d;
   logic [SEG_W-1:0]   dis_b_q, dis_b_d;
   logic [SEG_W-1:0]   dis_c_q, dis_c_d;
   logic [SEG_W-1:0]   dis_d_q, dis_d_d;

   logic [1:0]         ready_s;
   logic               xfer_s;
   logic               win_s;
   logic [VALUE_W-1:0] data_s;
   logic [SEG_W-1:0]   seg_a_s, seg_b_s, seg_c_s, seg_d_s;
   logic               blank_a_s, blank_b_s, blank_c_s;

   // Grant selection: which requester may transfer this cycle.
   always_comb begin
      ready_s = 2'b00;
      case (state_q)
         IDLE: begin
            if (req_valid == 2'b11) begin
               ready_s = ptr_q ? 2'b10 : 2'b01;
            end else begin
               ready_s = req_valid;
            end
         end
         SHOW: begin
            ready_s = owner_q ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]};
         end
         EXPIRED: begin
            if (req_valid[~owner_q]) begin
               ready_s = owner_q ? 2'b01 : 2'b10;
            end else begin
               ready_s = owner_q ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]};
            end
         end
         default: begin
            ready_s = 2'b00;
         end
      endcase
   end

   // No handshake can complete while reset is held.
   assign req_ready = rst_n ? ready_s : 2'b00;
   assign xfer_s    = |(ready_s & req_valid);
   assign win_s     = ready_s[1];
   assign data_s    = win_s ? req_data1 : req_data0;

   hex_to_seg u_seg_a (.nibble(data_s[15:12]), .seg(seg_a_s));
   hex_to_seg u_seg_b (.nibble(data_s[11:8]),  .seg(seg_b_s));
   hex_to_seg u_seg_c (.nibble(data_s[7:4]),   .seg(seg_c_s));
   hex_to_seg u_seg_d (.nibble(data_s[3:0]),   .seg(seg_d_s));

`ifdef SEG_BLANK_LEADING_ZEROS_EN
   // A digit blanks when it and every digit to its left are zero; the rightmost never blanks.
   assign blank_a_s = (data_s[15:12] == 4'd0);
   assign blank_b_s = blank_a_s && (data_s[11:8] == 4'd0);
   assign blank_c_s = blank_b_s && (data_s[7:4] == 4'd0);
`else
   assign blank_a_s = 1'b0;
   assign blank_b_s = 1'b0;
   assign blank_c_s = 1'b0;
`endif

   // Next-state logic for ownership, dwell counter, pointer and display latches.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      owner_valid_d = owner_valid_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE: begin
            if (xfer_s) begin
               state_d       = SHOW;
               owner_d       = win_s;
               owner_valid_d = 1'b1;
               cnt_d         = '0;
               ptr_d         = ~ptr_q;
            end else begin
               state_d = IDLE;
            end
         end
         SHOW: begin
            // Owner updates do not restart the dwell; the counter just keeps running.
            if (cnt_q >= CNT_PRE) begin
               cnt_d   = CNT_LAST;
               state_d = EXPIRED;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = SHOW;
            end
         end
         EXPIRED: begin
            if (xfer_s && (win_s != owner_q)) begin
               owner_d = win_s;
               cnt_d   = '0;
               state_d = SHOW;
            end else begin
               state_d = EXPIRED;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (xfer_s) begin
         dis_a_d = blank_a_s ? SEG_BLANK : seg_a_s;
         dis_b_d = blank_b_s ? SEG_BLANK : seg_b_s;
         dis_c_d = blank_c_s ? SEG_BLANK : seg_c_s;
         dis_d_d = seg_d_s;
      end else begin
         dis_a_d = dis_a_q;
         dis_b_d = dis_b_q;
         dis_c_d = dis_c_q;
         dis_d_d = dis_d_q;
      end
   end

   // State and output registers with asynchronous clear to the blank display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         owner_valid_q <= 1'b0;
         ptr_q         <= 1'b0;
         cnt_q         <= '0;
         dis_a_q       <= SEG_BLANK;
         dis_b_q       <= SEG_BLANK;
         dis_c_q       <= SEG_BLANK;
         dis_d_q       <= SEG_BLANK;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         dis_a_q       <= dis_a_d;
         dis_b_q       <= dis_b_d;
         dis_c_q       <= dis_c_d;
         dis_d_q       <= dis_d_d;
      end
   end

   assign dis_a       = dis_a_q;
   assign dis_b       = dis_b_q;
   assign dis_c       = dis_c_q;
   assign dis_d       = dis_d_q;
   assign owner       = owner_q;
   assign owner_valid = owner_valid_q;

endmodule
